// File: rtl/serial_subtractor_8.sv
// Bit-serial two's-complement subtractor: o = a - b - bi, one bit per clock.
// A single full-subtractor cell walks the latched operands LSB first. Each
// difference bit enters a right-shifting result register at the MSB, and the
// borrow is carried in a flop. Outputs change only when an operation completes.
module serial_subtractor_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] o,
   output logic             bo,
   output logic             ov,
   output logic             z
);

   localparam int CW = $clog2(WIDTH) + 1;  // bit-cycle counter width
   localparam int IW = $clog2(WIDTH);      // bit index width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sr;
   logic             borrow;
   logic [CW-1:0]    count;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             borrow_next;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] o_next;

   // Full-subtractor cell on the current bit, plus the shifted result it produces.
   always_comb begin
      a_bit       = a_q[count[IW-1:0]];
      b_bit       = b_q[count[IW-1:0]];
      d_bit       = a_bit ^ b_bit ^ borrow;
      borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
      o_next      = {d_bit, sr[WIDTH-1:1]};
      last_bit    = (count == CW'(WIDTH - 1));
      // A request is taken in IDLE and also in DONE, so back-to-back operations work.
      accept      = start && (state != BUSY);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every flop is written with <= so all registers update from
      // pre-edge values, whatever order the statements appear in.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic and the handshake outputs decoded from the state.
   always_comb begin
      // NOTE: defaults come first so that every path assigns every output and
      // no latch is inferred.
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? BUSY : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, the bit-serial datapath, and the result/flag registers
   // that load only on the final bit.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the operand and shift registers are reset as well. This is not
      // needed for correct results, but it makes every state after reset
      // deterministic.
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         sr     <= '0;
         borrow <= 1'b0;
         count  <= '0;
         o      <= '0;
         bo     <= 1'b0;
         ov     <= 1'b0;
         z      <= 1'b0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         borrow <= bi;
         count  <= '0;
      end else if (state == BUSY) begin
         sr     <= o_next;
         borrow <= borrow_next;
         count  <= count + 1'b1;
         if (last_bit) begin
            o  <= o_next;
            bo <= borrow_next;
            ov <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (o_next[WIDTH-1] ^ a_q[WIDTH-1]);
            z  <= (o_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor_8.sv
// Directed testbench for serial_subtractor_8. All expected values are
// hand-computed. Inputs are driven and outputs sampled on the falling edge.
module tb_serial_subtractor_8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bi;
   logic       busy;
   logic       done;
   logic [7:0] o;
   logic       bo;
   logic       ov;
   logic       z;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] last_o   = 8'h00;

   serial_subtractor_8 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy),
      .done  (done),
      .o     (o),
      .bo    (bo),
      .ov    (ov),
      .z     (z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full operation. With noisy set, the operands are scrambled and start
   // is toggled while the unit is busy.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tbi, input logic [7:0] eo, input logic ebo,
                         input logic eov, input logic ez, input bit noisy);
      int n_busy;
      bit seen;
      @(negedge clk);
      a = ta; b = tb_v; bi = tbi; start = 1'b1;
      @(negedge clk);                        // acceptance edge has passed
      start = 1'b0;
      if (noisy) begin a = ~ta; b = ~tb_v; bi = ~tbi; end
      check({tag, " hold_o"}, 32'(o), 32'(last_o));
      n_busy = busy ? 1 : 0;
      seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
            break;
         end
         if (busy) n_busy++;
         if (noisy) begin
            a     = 8'($urandom);
            b     = 8'($urandom);
            bi    = 1'($urandom);
            start = n_busy[0];
         end
      end
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " busy_cycles"}, 32'(n_busy), 32'd8);
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check({tag, " o"}, 32'(o), 32'(eo));
      check({tag, " flags"}, {29'd0, bo, ov, z}, {29'd0, ebo, eov, ez});
      last_o = eo;
      @(negedge clk);
      check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bi;
      logic [7:0] o;
      logic       bo;
      logic       ov;
      logic       z;
   } vec_t;

   vec_t b2b [4];

   initial begin
      int gap;
      int n_done;
      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bi = 1'b0;
      #1;
      check("reset outputs", {22'd0, busy, done, o}, 32'd0);
      check("reset flags", {29'd0, bo, ov, z}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Basic subtraction with latency and handshake checks.
      run_op("op44_25", 8'h44, 8'h25, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset partway through an operation: the operation is discarded and no done appears.
      @(negedge clk);
      a = 8'h12; b = 8'h34; bi = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst o", 32'(o), 32'd0);
      check("midrst flags", {29'd0, bo, ov, z}, 32'd0);
      check("midrst busy_done", {30'd0, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      check("midrst no_activity", 32'(n_done), 32'd0);
      last_o = 8'h00;

      run_op("op99_83_bi", 8'h99, 8'h83, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("op25_44", 8'h25, 8'h44, 1'b0, 8'hE1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("op80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("op3C_3C", 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      run_op("op00_FF_bi", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("op00_FF_noisy", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      run_op("op44_25_noisy", 8'h44, 8'h25, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back: start held high. Operands are junk except at each acceptance edge.
      b2b[0] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
      b2b[1] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
      b2b[2] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      b2b[3] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      a = b2b[0].a; b = b2b[0].b; bi = b2b[0].bi; start = 1'b1;
      for (int j = 0; j < 4; j++) begin
         gap = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gap++;
            if (done) break;
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
         end
         check($sformatf("b2b%0d gap", j), 32'(gap), 32'd9);
         check($sformatf("b2b%0d o", j), 32'(o), 32'(b2b[j].o));
         check($sformatf("b2b%0d flags", j), {29'd0, bo, ov, z},
               {29'd0, b2b[j].bo, b2b[j].ov, b2b[j].z});
         check($sformatf("b2b%0d busy_at_done", j), 32'(busy), 32'd0);
         if (j < 3) begin
            a = b2b[j+1].a; b = b2b[j+1].b; bi = b2b[j+1].bi;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      check("final idle", {30'd0, busy, done}, 32'd0);
      check("final o held", 32'(o), 32'h4B);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
